// File: rtl/frogger_pkg.sv
// Shared game-state types and widths for the frogger blocks.
// Provides the life-count width, the life state enum and the width of the
// per-frame down counters.
package frogger_pkg;

    localparam int LIVES_W     = 2;
    localparam int MAX_LIVES   = 3;
    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        DYING     = 2'd1,
        RESPAWN   = 2'd2,
        GAME_OVER = 2'd3
    } life_state_t;

endpackage

// File: rtl/life_manager_if.sv
// Bundle of the life manager's game-side signals.
//   frame_tick, hit, start_btn, level_done : game/VGA side -> life manager
//   lives, frog_freeze, frog_respawn,
//   invulnerable, game_over                : life manager -> HUD / frog logic
// Modports: master = game side driving the events, slave = life manager.
interface life_manager_if;
    import frogger_pkg::*;

    logic               frame_tick;
    logic               hit;
    logic               start_btn;
    logic               level_done;
    logic [LIVES_W-1:0] lives;
    logic               frog_freeze;
    logic               frog_respawn;
    logic               invulnerable;
    logic               game_over;

    modport master (
        output frame_tick, hit, start_btn, level_done,
        input  lives, frog_freeze, frog_respawn, invulnerable, game_over
    );

    modport slave (
        input  frame_tick, hit, start_btn, level_done,
        output lives, frog_freeze, frog_respawn, invulnerable, game_over
    );

endinterface

// File: rtl/frame_countdown.sv
// Loadable 8-bit frame counter that counts down on frame_tick and holds at 0.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (count -> 0)
//   load        : load load_value this cycle (takes priority over a tick)
//   load_value  : value to load
//   frame_tick  : decrement enable, one pulse per frame
//   zero        : the count will be 0 after this edge (look-ahead), so the
//                 owner can act on the edge that samples the final tick
//   running     : the current count is non-zero
module frame_countdown
    import frogger_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [FRAME_CNT_W-1:0] load_value,
    input  logic                   frame_tick,
    output logic                   zero,
    output logic                   running
);

    logic [FRAME_CNT_W-1:0] count_q;
    logic [FRAME_CNT_W-1:0] count_d;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (frame_tick && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero    = (count_d == '0);
    assign running = (count_q != '0);

endmodule

// File: rtl/life_manager.sv
// Frog life manager: owns the life count and sequences death pause, respawn,
// post-respawn invulnerability and game over.
// Ports:
//   clk    : system/pixel clock
//   rst_n  : synchronous active-low reset
//   bus    : life_manager_if.slave (frame_tick, hit, start_btn, level_done in;
//            lives, frog_freeze, frog_respawn, invulnerable, game_over out)
// Parameters: START_LIVES (1-3), DEATH_FRAMES (1-255), INVULN_FRAMES (0-255).
// Build option: define LIFE_BONUS_EN to let level_done add a life in PLAY
// (saturating at MAX_LIVES); otherwise level_done is ignored.
module life_manager
    import frogger_pkg::*;
#(
    parameter int START_LIVES   = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 90
) (
    input  logic                 clk,
    input  logic                 rst_n,
    life_manager_if.slave        bus
);

    life_state_t        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               start_q;
    logic               start_rise;
    logic               freeze_q, respawn_q, over_q;

    logic hit_taken;
    logic death_tick, death_zero, death_running;
    logic inv_load, inv_tick, inv_zero, inv_running;

    // A hit only counts in PLAY outside the invulnerability window. The
    // invulnerability tick is dropped in the cycle a hit is taken.
    assign hit_taken  = (state_q == PLAY) && bus.hit && !inv_running;
    assign death_tick = (state_q == DYING) && bus.frame_tick;
    assign inv_load   = (state_q == RESPAWN);
    assign inv_tick   = (state_q == PLAY) && bus.frame_tick && !hit_taken;
    assign start_rise = bus.start_btn && !start_q;

    frame_countdown u_death_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (hit_taken),
        .load_value (FRAME_CNT_W'(DEATH_FRAMES)),
        .frame_tick (death_tick),
        .zero       (death_zero),
        .running    (death_running)
    );

    frame_countdown u_inv_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (inv_load),
        .load_value (FRAME_CNT_W'(INVULN_FRAMES)),
        .frame_tick (inv_tick),
        .zero       (inv_zero),
        .running    (inv_running)
    );

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        case (state_q)
            PLAY: begin
                if (hit_taken) begin
                    lives_d = lives_q - 1'b1;
                    state_d = DYING;
                end
`ifdef LIFE_BONUS_EN
                else if (bus.level_done && lives_q != LIVES_W'(MAX_LIVES)) begin
                    lives_d = lives_q + 1'b1;
                end
`endif
            end
            DYING: begin
                // death_zero is asserted on the edge that samples the final tick.
                if (death_zero) begin
                    state_d = (lives_q != '0) ? RESPAWN : GAME_OVER;
                end
            end
            RESPAWN: begin
                state_d = PLAY;
            end
            GAME_OVER: begin
                if (start_rise) begin
                    lives_d = LIVES_W'(START_LIVES);
                    state_d = RESPAWN;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= PLAY;
            lives_q   <= LIVES_W'(START_LIVES);
            start_q   <= 1'b1;  // a button held through reset must not restart
            freeze_q  <= 1'b0;
            respawn_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            start_q   <= bus.start_btn;
            freeze_q  <= (state_d != PLAY);
            respawn_q <= (state_d == RESPAWN);
            over_q    <= (state_d == GAME_OVER);
        end
    end

    assign bus.lives        = lives_q;
    assign bus.frog_freeze  = freeze_q;
    assign bus.frog_respawn = respawn_q;
    assign bus.invulnerable = inv_running;
    assign bus.game_over    = over_q;

    logic unused_flags;
`ifdef LIFE_BONUS_EN
    assign unused_flags = inv_zero ^ death_running;
`else
    assign unused_flags = inv_zero ^ death_running ^ bus.level_done;
`endif

endmodule

// File: tb/tb_life_manager.sv
// Self-checking bench for life_manager: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model of lives / death pause / invulnerability / game over.
module tb_life_manager;
    import frogger_pkg::*;

    localparam int START  = 3;
    localparam int DEATH  = 60;
    localparam int INVULN = 90;

    logic clk = 1'b0;
    logic rst_n;
    bit   btn;
    bit   cmp_en;
    int   total_checks;
    int   passed_checks;
    int   respawn_seen;

    always #5 clk = ~clk;

    life_manager_if bus ();

    life_manager #(
        .START_LIVES   (START),
        .DEATH_FRAMES  (DEATH),
        .INVULN_FRAMES (INVULN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_lives;
    int m_dead_left;   // death-pause frames remaining; >0 means the frog is dead
    int m_inv_left;    // invulnerability frames remaining
    bit m_resp;        // respawn cycle in progress
    bit m_over;        // game over
    bit m_prev_btn;

    always @(posedge clk) begin
        bit rise;
        if (!rst_n) begin
            m_lives     = START;
            m_dead_left = 0;
            m_inv_left  = 0;
            m_resp      = 0;
            m_over      = 0;
            m_prev_btn  = 1;
        end else begin
            rise       = bus.start_btn && !m_prev_btn;
            m_prev_btn = bus.start_btn;
            if (m_resp) begin
                m_resp     = 0;
                m_inv_left = INVULN;
            end else if (m_over) begin
                if (rise) begin
                    m_lives = START;
                    m_over  = 0;
                    m_resp  = 1;
                end
            end else if (m_dead_left > 0) begin
                if (bus.frame_tick) begin
                    m_dead_left--;
                    if (m_dead_left == 0) begin
                        if (m_lives > 0) m_resp = 1;
                        else             m_over = 1;
                    end
                end
            end else begin
                if (bus.hit && m_inv_left == 0) begin
                    m_lives--;
                    m_dead_left = DEATH;
                end else begin
                    if (bus.frame_tick && m_inv_left > 0) m_inv_left--;
`ifdef LIFE_BONUS_EN
                    if (bus.level_done && m_lives < MAX_LIVES) m_lives++;
`endif
                end
            end
        end
    end

    // Single compare process: outputs are checked mid-cycle against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("lives",        8'(bus.lives),        8'(m_lives));
            check("frog_freeze",  8'(bus.frog_freeze),  8'(m_dead_left > 0 || m_resp || m_over));
            check("frog_respawn", 8'(bus.frog_respawn), 8'(m_resp));
            check("invulnerable", 8'(bus.invulnerable), 8'(m_inv_left > 0));
            check("game_over",    8'(bus.game_over),    8'(m_over));
        end
    end

    always @(negedge clk) begin
        if (bus.frog_respawn === 1'b1) respawn_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit h, input bit t, input bit l);
        @(negedge clk);
        bus.hit        = h;
        bus.frame_tick = t;
        bus.level_done = l;
        bus.start_btn  = btn;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            step(0, 1, 0);
            step(0, 0, 0);
            step(0, 0, 0);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 0);
        after_edge();
        step(0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        respawn_seen  = 0;
        cmp_en        = 0;
        btn           = 0;
        rst_n         = 1'b0;
        bus.hit = 0; bus.frame_tick = 0; bus.level_done = 0; bus.start_btn = 0;

        // Reset state
        step(0, 0, 0);
        after_edge();
        check("reset_lives",   8'(bus.lives),        8'd3);
        check("reset_freeze",  8'(bus.frog_freeze),  8'd0);
        check("reset_respawn", 8'(bus.frog_respawn), 8'd0);
        check("reset_inv",     8'(bus.invulnerable), 8'd0);
        check("reset_over",    8'(bus.game_over),    8'd0);
        cmp_en = 1;
        step(0, 0, 0);
        rst_n = 1'b1;

`ifdef LIFE_BONUS_EN
        // Hit wins over a simultaneous bonus, then bonus saturates at 3
        step(1, 0, 1);
        after_edge();
        check("bonus_hit_wins", 8'(bus.lives), 8'd2);
        frames(DEATH);
        frames(INVULN);
        step(0, 0, 1);
        after_edge();
        check("bonus_inc", 8'(bus.lives), 8'd3);
        step(0, 0, 1);
        after_edge();
        check("bonus_sat", 8'(bus.lives), 8'd3);
        step(0, 0, 0);
        do_reset();
`endif

        // First hit: 3 -> 2 and freeze in the next cycle
        step(1, 0, 0);
        after_edge();
        check("hit1_lives",  8'(bus.lives),       8'd2);
        check("hit1_freeze", 8'(bus.frog_freeze), 8'd1);

        // Hit during the death pause is ignored
        frames(10);
        step(1, 0, 0);
        after_edge();
        check("dying_hit_lives", 8'(bus.lives), 8'd2);
        frames(DEATH - 10);
        check("respawn_count1", 8'(respawn_seen),     8'd1);
        check("inv_after_resp", 8'(bus.invulnerable), 8'd1);

        // Hit at invulnerability frame 45 ignored; after 90 frames it counts
        frames(45);
        step(1, 0, 0);
        after_edge();
        check("inv_hit_lives", 8'(bus.lives), 8'd2);
        frames(INVULN - 45);
        check("inv_expired", 8'(bus.invulnerable), 8'd0);
        step(1, 0, 0);
        after_edge();
        check("hit2_lives", 8'(bus.lives), 8'd1);
        frames(DEATH);
        check("respawn_count2", 8'(respawn_seen), 8'd2);

        // Last life lost with the start button already held
        frames(INVULN);
        step(1, 0, 0);
        after_edge();
        check("hit3_lives", 8'(bus.lives), 8'd0);
        btn = 1;
        frames(DEATH);
        check("game_over_set",   8'(bus.game_over), 8'd1);
        check("no_respawn_dead", 8'(respawn_seen),  8'd2);
        repeat (5) step(1, 1, 1);
        check("held_btn_no_restart", 8'(bus.game_over), 8'd1);
        check("game_over_lives",     8'(bus.lives),     8'd0);

        // Release then press restarts the game
        btn = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        btn = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("restart_lives",   8'(bus.lives),     8'd3);
        check("restart_over",    8'(bus.game_over), 8'd0);
        check("restart_respawn", 8'(respawn_seen),  8'd3);
        btn = 0;

        // Reset in the middle of the death pause
        frames(INVULN);
        step(1, 0, 0);
        frames(30);
        rst_n = 1'b0;
        step(0, 0, 0);
        after_edge();
        check("midreset_lives",  8'(bus.lives),       8'd3);
        check("midreset_freeze", 8'(bus.frog_freeze), 8'd0);
        check("midreset_over",   8'(bus.game_over),   8'd0);
        step(0, 0, 0);
        rst_n = 1'b1;

        // Randomized phase against the model
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 15) == 0) btn = ~btn;
            rst_n = ($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1;
            step($urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0);
        end
        rst_n = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/life_manager.md
# life_manager

Game-state block that owns the frog's remaining-life count and drives the `lives` input of the HUD heart display. It consumes collision pulses from the frog/obstacle logic and the per-frame tick from the VGA timing generator. It sequences death delay, respawn, post-respawn invulnerability and game over, and it issues respawn and freeze controls to the frog movement logic.

## Interface

Parameters:
- `START_LIVES`, default 3: lives loaded at reset and at restart; legal range 1–3.
- `DEATH_FRAMES`, default 60: frames spent in the death pause before respawn or game over; legal range 1–255.
- `INVULN_FRAMES`, default 90: frames after respawn during which hits are ignored; 0 disables invulnerability; legal range 0–255.

Ports, clock and reset first:
- `clk`, input, 1: system/pixel clock. This is the only clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `frame_tick`, input, 1: one-cycle pulse, once per VGA frame at vsync start.
- `hit`, input, 1: one-cycle pulse when the frog collides or drowns.
- `start_btn`, input, 1: level signal, already debounced.
- `level_done`, input, 1: one-cycle pulse when the frog reaches the goal row. Used only with the bonus macro.
- `lives`, output, 2: remaining lives, 0–3. Connects directly to the heart display.
- `frog_freeze`, output, 1: high while frog movement must be ignored.
- `frog_respawn`, output, 1: one-cycle pulse that returns the frog to its start cell.
- `invulnerable`, output, 1: high during the invulnerability window.
- `game_over`, output, 1: high in the GAME_OVER state.

## Operation

State machine with four states:
- PLAY
  - Not invulnerable and `hit`=1: `lives` ← `lives`−1, load the frame counter with DEATH_FRAMES, go to DYING.
  - `hit` while invulnerable is ignored.
- DYING
  - `frog_freeze`=1. The counter decrements on each `frame_tick`.
  - When the counter reaches 0: if `lives`≠0, go to RESPAWN; otherwise go to GAME_OVER.
  - `hit` is ignored.
- RESPAWN
  - Lasts exactly one cycle. `frog_respawn`=1 and `frog_freeze`=1.
  - Load the invulnerability counter with INVULN_FRAMES, then go to PLAY.
- GAME_OVER
  - `frog_freeze`=1 and `game_over`=1. `hit` and `level_done` are ignored.
  - On a rising edge of `start_btn`: `lives` ← START_LIVES, pass through RESPAWN, return to PLAY.

Invulnerability:
- `invulnerable`=1 while the invulnerability counter is non-zero. The counter decrements on `frame_tick` in PLAY.

Start edge detection:
- `start_btn` is registered once.
- A rising edge is current=1 and previous=0. Holding the button high does not retrigger a restart.

Arithmetic:
- `lives` never wraps below 0. A decrement is only possible from PLAY, and PLAY implies `lives`≥1.
- Both frame counters are 8 bits wide and saturate at 0.

Reset values:
- State = PLAY, `lives`=START_LIVES.
- `frog_freeze`=0, `frog_respawn`=0, `invulnerable`=0, `game_over`=0.
- Both counters = 0. Start edge register = 1, so a button held through reset does not trigger a restart.

## Timing

- All outputs are registered.
- `hit` sampled at edge N: `lives` and state update at edge N, and the new values are visible in the cycle after N. `frog_freeze` rises in that same cycle.
- DYING lasts exactly DEATH_FRAMES `frame_tick` pulses.
  - The DYING→RESPAWN transition happens at the edge that samples the final tick.
  - `frog_respawn` is high for the single following cycle.
- Restart: `game_over` falls one cycle after the `start_btn` rising edge is detected.
- `hit` and `frame_tick` in the same cycle in PLAY: the hit is applied. The invulnerability tick in that cycle is discarded.
- `rst_n` low at any edge, including mid-DYING or in GAME_OVER, forces all reset values at that edge.

## Configuration

- `LIFE_BONUS_EN`, defined:
  - In PLAY, a `level_done` pulse increments `lives`, saturating at 3.
  - If `hit` and `level_done` arrive in the same cycle, the hit wins and the bonus is dropped.
- `LIFE_BONUS_EN`, undefined:
  - `level_done` is unused, and the port remains so the interface does not change.
  - `lives` only decreases or reloads.

## Structure

Shared package `frogger_pkg`:
- `LIVES_W`=2 and `MAX_LIVES`=3.
- `life_state_t` enum covering PLAY, DYING, RESPAWN and GAME_OVER, with 2-bit encoding.
- `FRAME_CNT_W`=8.

Sub-module `frame_countdown`, instantiated twice (death and invulnerability counters):
- Inputs: load, load value, `frame_tick`.
- Outputs: `zero` flag and `running`.

## Test plan

- Reset, then 1 hit in PLAY: `lives` 3→2 one cycle later and `frog_freeze`=1. After 60 ticks, one `frog_respawn` pulse and `invulnerable`=1.
- Hit during DYING and again at invulnerability frame 45: `lives` stays 2. A hit after 90 ticks decrements to 1.
- Three hits, each after the previous invulnerability has expired: `lives`=0. After 60 ticks, `game_over`=1 and no `frog_respawn`.
- In GAME_OVER with `start_btn` held high from before entry: no restart. A release followed by a press gives `lives`=3, one `frog_respawn`, and `game_over`=0.
- `rst_n` low at DYING frame 30: next cycle `lives`=3, `frog_freeze`=0, state PLAY.
- With `LIFE_BONUS_EN`: `level_done` at `lives`=2 gives 3, and a further `level_done` stays at 3. `hit` and `level_done` in the same cycle at `lives`=3 gives 2.
